// File: rtl/vga_pkg.sv
// +----------------------------------------------------------------------+
// | vga_pkg: pixel geometry, widths and shared typedefs for the VGA path |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;
  localparam int DATA_W   = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [DATA_W-1:0]      pixel_t;
  typedef logic [ROW_W+COL_W-1:0] pix_addr_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/vram_arbiter_sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with combinational head and full/empty  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// +----------------------------------------------------------------------+
// | vram_arbiter: shares pixel RAM between VGA reads, writer and clear   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ROW_W      = vga_pkg::ROW_W,
  parameter int COL_W      = vga_pkg::COL_W,
  parameter int DATA_W     = vga_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vga_rdn,
  input  logic [ROW_W-1:0]       vga_row,
  input  logic [COL_W-1:0]       vga_col,
  output logic [DATA_W-1:0]      vga_dout,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ROW_W-1:0]       wr_row,
  input  logic [COL_W-1:0]       wr_col,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clr_req,
  input  logic [DATA_W-1:0]      clr_color,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic [ROW_W+COL_W-1:0] ram_addr,
  output logic                   ram_we,
  output logic [DATA_W-1:0]      ram_wdata,
  input  logic [DATA_W-1:0]      ram_rdata
);

  localparam int ADDR_W  = ROW_W + COL_W;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ROW_W-1:0]   head_row;
  logic [COL_W-1:0]   head_col;
  logic [DATA_W-1:0]  head_data;
  logic               head_in_range;

  arb_state_e         state_q, state_d;
  logic [ROW_W-1:0]   crow_q, crow_d;
  logic [COL_W-1:0]   ccol_q, ccol_d;
  logic [DATA_W-1:0]  color_q, color_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_slot_q, rd_slot_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({wr_row, wr_col, wr_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_row      = fifo_head[ENTRY_W-1 -: ROW_W];
  assign head_col      = fifo_head[DATA_W +: COL_W];
  assign head_data     = fifo_head[DATA_W-1:0];
  assign head_in_range = (head_col < COL_W'(H_ACTIVE)) && (head_row < ROW_W'(V_ACTIVE));

  always_comb begin
    state_d   = state_q;
    crow_d    = crow_q;
    ccol_d    = ccol_q;
    color_d   = color_q;
    done_d    = 1'b0;
    rd_slot_d = 1'b0;
    fifo_pop  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;

    if (!vga_rdn) begin
      ram_addr  = {vga_row, vga_col};
      rd_slot_d = 1'b1;
    end else if (state_q == ST_CLEAR) begin
      ram_addr  = {crow_q, ccol_q};
      ram_we    = 1'b1;
      ram_wdata = color_q;
      if (ccol_q == COL_W'(H_ACTIVE-1)) begin
        ccol_d = '0;
        if (crow_q == ROW_W'(V_ACTIVE-1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          crow_d = crow_q + ROW_W'(1);
        end
      end else begin
        ccol_d = ccol_q + COL_W'(1);
      end
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      if (head_in_range) begin
        ram_we    = 1'b1;
        ram_addr  = {head_row, head_col};
        ram_wdata = head_data;
      end
    end

    if (state_q == ST_IDLE && clr_req) begin
      state_d = ST_CLEAR;
      color_d = clr_color;
      crow_d  = '0;
      ccol_d  = '0;
    end
    busy_d = (state_d == ST_CLEAR);

    // Keep the RAM port quiet and at address 0 while held in reset.
    if (!rst_n) begin
      fifo_pop  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
    end

    addr_d  = ram_addr;
    wdata_d = ram_wdata;
    dout_d  = rd_slot_q ? ram_rdata : dout_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      crow_q    <= '0;
      ccol_q    <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_slot_q <= 1'b0;
      dout_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      crow_q    <= crow_d;
      ccol_q    <= ccol_d;
      color_q   <= color_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_slot_q <= rd_slot_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign vga_dout = dout_q;

endmodule

`default_nettype wire
